// File: rtl/rd53_popcount_seq.sv
// Sequential popcount: one shared 5-input weight unit walks the latched operand
// chunk by chunk (LSBs first) and reports count, parity and majority.
module rd53_popcount_seq #(
  parameter int CHUNKS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [5*CHUNKS-1:0]   in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            out_count,
  output logic                  out_odd,
  output logic                  out_major,
  output logic                  busy
);

  localparam int W     = 5 * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);
  localparam logic [6:0]       W_LIM    = 7'(W);

  function automatic logic [2:0] weight5(input logic [4:0] b);
    weight5 = 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]) + 3'(b[4]);
  endfunction

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     operand;
  logic [5:0]       acc;
  logic [4:0]       chunk;
  logic [2:0]       chunk_wt;
  logic [6:0]       acc_x2;

  // Chunk selector feeding the single shared weight unit
  always_comb begin
    chunk = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (idx == IDX_W'(c)) chunk = operand[5*c +: 5];
    end
  end

  assign chunk_wt = weight5(chunk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      operand <= '0;
      acc     <= '0;
    end else if (clear) begin
      state <= S_IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            operand <= in_data;
            acc     <= '0;
            idx     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc + 6'(chunk_wt);
          if (idx == IDX_LAST) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
            idx   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
          acc   <= '0;
        end
      endcase
    end
  end

  // Result ports are forced to zero unless a result is being offered
  assign acc_x2    = {acc, 1'b0};
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign out_count = out_valid ? acc : 6'd0;
  assign out_odd   = out_valid && acc[0];
  assign out_major = out_valid && (acc_x2 > W_LIM);

endmodule
